// File: rtl/nibble_serial_sub16.sv
// Slice-serial subtractor.
// Computes a - b - b_in one SLICE-bit slice per cycle, LSB slice first,
// with a ripple-borrow chain inside each slice and a registered borrow
// carried between slices. Results are registered and held until the next
// completion.
module nibble_serial_sub16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [SLICE-1:0] sa, sb, sres;
  logic             sbout;
  logic             accept;
  logic             last;

  // SLICE-bit ripple-borrow subtractor: returns {borrow_out, difference}.
  function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             bin);
    logic [SLICE-1:0] r;
    logic             br;
    r  = '0;
    br = bin;
    for (int i = 0; i < SLICE; i++) begin
      r[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, r};
  endfunction

  // A request is taken whenever no subtraction is running (IDLE or DONE).
  assign accept = start && (state_q != RUN);
  assign last   = (k_q == KW'(NSL - 1));

  // Select the operand slice addressed by the slice index and subtract it.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (k_q == KW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    {sbout, sres} = sub_slice(sa, sb, brw_q);
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          brw_d   = b_in;
          part_d  = '0;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NSL; i++) begin
          if (k_q == KW'(i)) part_d[i*SLICE +: SLICE] = sres;
        end
        brw_d = sbout;
        k_d   = k_q + KW'(1);
        if (last) begin
          // Final slice: publish the full result along with both flags.
          k_d     = '0;
          diff_d  = part_d;
          b_out_d = sbout;
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (part_d[WIDTH-1] ^ a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign b_out    = b_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Testbench for nibble_serial_sub16: directed and random subtractions
// checked against a plain-arithmetic reference model.
module tb_nibble_serial_sub16;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             b_in;
  logic             busy, done;
  logic [WIDTH-1:0] diff;
  logic             b_out, overflow;

  int n_pass  = 0;
  int n_total = 0;

  nibble_serial_sub16 #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .b_out    (b_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic.
  function automatic logic [WIDTH-1:0] m_diff(input logic [WIDTH-1:0] x, y, input logic bi);
    logic [WIDTH:0] t;
    t = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic m_bout(input logic [WIDTH-1:0] x, y, input logic bi);
    int unsigned xv, yv;
    xv = x;
    yv = y;
    return (xv < yv + (bi ? 1 : 0));
  endfunction

  function automatic logic m_ovf(input logic [WIDTH-1:0] x, y, input logic bi);
    logic [WIDTH-1:0] d;
    d = m_diff(x, y, bi);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #2;
    n_total++;
    if ({busy, done, b_out, overflow} !== 4'b0 || diff !== '0)
      $display("FAIL reset_state busy=%b done=%b diff=%h b_out=%b ovf=%b required all 0",
               busy, done, diff, b_out, overflow);
    else n_pass++;
    // start must not be taken while reset is held
    start = 1'b1; a = 16'h00FF; b = 16'h0001;
    tick(); tick();
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_in_reset busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    logic [WIDTH-1:0] va[$], vb[$];
    logic             vbi[$];
    logic [WIDTH-1:0] ea, eb, ed;
    logic             ebi;
    logic             lat_ok;
    va.push_back(16'h1234); vb.push_back(16'h0234); vbi.push_back(1'b0);
    va.push_back(16'h0000); vb.push_back(16'h0001); vbi.push_back(1'b0);
    va.push_back(16'h8000); vb.push_back(16'h0001); vbi.push_back(1'b0);
    va.push_back(16'h0000); vb.push_back(16'hFFFF); vbi.push_back(1'b1);
    va.push_back(16'h7FFF); vb.push_back(16'hFFFF); vbi.push_back(1'b0);
    va.push_back(16'hFFFF); vb.push_back(16'hFFFF); vbi.push_back(1'b1);
    for (int i = 0; i < 24; i++) begin
      va.push_back(16'($urandom));
      vb.push_back(($urandom_range(0, 3) == 0) ? va[va.size()-1] : 16'($urandom));
      vbi.push_back(1'($urandom));
    end
    for (int n = 0; n < va.size(); n++) begin
      ea = va[n]; eb = vb[n]; ebi = vbi[n];
      ed = m_diff(ea, eb, ebi);
      a = ea; b = eb; b_in = ebi; start = 1'b1;
      tick();
      start = 1'b0;
      // operand changes after acceptance must not matter
      a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
      lat_ok = (busy === 1'b1) && (done === 1'b0);
      for (int c = 1; c < LAT; c++) begin
        tick();
        if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
      end
      tick();
      n_total++;
      if (!lat_ok || done !== 1'b1 || busy !== 1'b0)
        $display("FAIL latency[%0d] done=%b busy=%b lat_ok=%b required done=1 busy=0 after %0d cycles",
                 n, done, busy, lat_ok, LAT);
      else n_pass++;
      n_total++;
      if (diff !== ed)
        $display("FAIL diff[%0d] a=%h b=%h bi=%b got %h expected %h", n, ea, eb, ebi, diff, ed);
      else n_pass++;
      n_total++;
      if (b_out !== m_bout(ea, eb, ebi) || overflow !== m_ovf(ea, eb, ebi))
        $display("FAIL flags[%0d] a=%h b=%h bi=%b got b_out=%b ovf=%b expected b_out=%b ovf=%b",
                 n, ea, eb, ebi, b_out, overflow, m_bout(ea, eb, ebi), m_ovf(ea, eb, ebi));
      else n_pass++;
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== ed)
        $display("FAIL pulse_hold[%0d] done=%b busy=%b diff=%h expected 0 0 %h",
                 n, done, busy, diff, ed);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a1, b1, a2, b2, d1, d2;
    logic             bi2;
    logic             ok;
    a1 = 16'h1111; b1 = 16'h0101; d1 = m_diff(a1, b1, 1'b0);
    a2 = 16'h0005; b2 = 16'h0ABC; bi2 = 1'b1; d2 = m_diff(a2, b2, bi2);
    a = a1; b = b1; b_in = 1'b0; start = 1'b1;
    tick();
    ok = 1'b1;
    // start kept high with different operands through every busy cycle
    for (int c = 1; c <= LAT; c++) begin
      a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
      tick();
      if (c < LAT && (busy !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    n_total++;
    if (!ok || done !== 1'b1 || diff !== d1 || b_out !== m_bout(a1, b1, 1'b0))
      $display("FAIL ignore_busy_start done=%b ok=%b diff=%h b_out=%b expected done=1 diff=%h",
               done, ok, diff, b_out, d1);
    else n_pass++;
    // start still high during DONE: second operation accepted immediately
    a = a2; b = b2; b_in = bi2;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept busy=%b done=%b required 1 0", busy, done);
    else n_pass++;
    ok = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT && (busy !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    n_total++;
    if (!ok || done !== 1'b1 || diff !== d2 || b_out !== m_bout(a2, b2, bi2)
        || overflow !== m_ovf(a2, b2, bi2))
      $display("FAIL b2b_second done=%b ok=%b diff=%h b_out=%b ovf=%b expected diff=%h",
               done, ok, diff, b_out, overflow, d2);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midop();
    logic ok;
    a = 16'h9000; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, b_out, overflow} !== 4'b0 || diff !== '0)
      $display("FAIL midop_reset busy=%b done=%b diff=%h b_out=%b ovf=%b required all 0",
               busy, done, diff, b_out, overflow);
    else n_pass++;
    ok = 1'b1;
    start = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    start = 1'b0;
    rst_n = 1'b1;
    n_total++;
    if (!ok)
      $display("FAIL midop_no_done saw busy or done during reset, required none");
    else n_pass++;
    tick();
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ok = (busy === 1'b1);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT && (busy !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    n_total++;
    if (!ok || done !== 1'b1 || diff !== 16'h0002 || b_out !== 1'b0 || overflow !== 1'b0)
      $display("FAIL after_reset_op done=%b ok=%b diff=%h b_out=%b ovf=%b expected done=1 diff=0002 0 0",
               done, ok, diff, b_out, overflow);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
